// File: rtl/sky_pkg.sv
// Shared definitions for the stacking game: screen geometry, colour codes,
// controller state encoding and the LFSR-to-colour mapping.
package sky_pkg;

  localparam int BLOCK_W    = 150;
  localparam int SCREEN_W   = 640;
  localparam int MAX_LAYERS = 15;

  localparam logic [1:0] COL_EMPTY = 2'b00;
  localparam logic [1:0] COL_GREEN = 2'b01;
  localparam logic [1:0] COL_RED   = 2'b10;
  localparam logic [1:0] COL_BLUE  = 2'b11;

  typedef enum logic [1:0] {
    ST_MOVE = 2'd0,
    ST_LAND = 2'd1,
    ST_FULL = 2'd2
  } state_e;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_e;

  // The empty code folds onto green so a placed layer is never blank.
  function automatic logic [1:0] map_color(input logic [1:0] code);
    logic [1:0] col;
    col = COL_GREEN;
    case (code)
      2'b00:   col = COL_GREEN;
      2'b01:   col = COL_GREEN;
      2'b10:   col = COL_RED;
      2'b11:   col = COL_BLUE;
      default: col = COL_GREEN;
    endcase
    return col;
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, taps 8,6,5,4, advancing every clock.
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] state
);

  always_ff @(posedge clk) begin
    if (rst) state <= SEED;
    else     state <= {state[6:0], state[7] ^ state[5] ^ state[4] ^ state[3]};
  end

endmodule

// File: rtl/stack_ctrl.sv
// Stacking-game controller: sweeps the block left/right on a divided tick and
// lands a coloured layer on each drop edge until the stack is full.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_MOVE | block sweeping; drop edge requests a landing
// ST_LAND | one cycle: write slot height+1, bump height
// ST_FULL | 15 layers placed; everything frozen until reset
module stack_ctrl
  import sky_pkg::*;
#(
  parameter int         TICK_DIV  = 1000000,
  parameter int         STEP      = 4,
  parameter int         X_MAX     = SCREEN_W - BLOCK_W,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        drop,
  output logic [9:0]  pos_x,
  output logic [31:0] colors,
  output logic [3:0]  height,
  output logic        game_over
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_e            state_q, state_nxt;
  dir_e              dir_q;
  logic [DIV_W-1:0]  div_q;
  logic              drop_q;
  logic [9:0]        pos_x_q;
  logic [31:0]       colors_q;
  logic [3:0]        height_q;
  logic              game_over_q;
  logic [7:0]        lfsr_state;

  logic              step;
  logic              drop_edge;
  logic              move_en;
  logic              land_en;
  logic [3:0]        height_inc;
  logic              land_full;
  logic [10:0]       pos_inc;
  logic              unused_lfsr;

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .state (lfsr_state)
  );

  assign unused_lfsr = ^lfsr_state[7:2];

  assign step       = (div_q == DIV_W'(TICK_DIV - 1));
  assign drop_edge  = drop && !drop_q;
  assign height_inc = height_q + 4'd1;
  assign land_full  = (height_inc == 4'(MAX_LAYERS));
  assign pos_inc    = {1'b0, pos_x_q} + 11'(STEP);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_MOVE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_MOVE: if (drop_edge) state_nxt = ST_LAND;
      ST_LAND: state_nxt = land_full ? ST_FULL : ST_MOVE;
      ST_FULL: state_nxt = ST_FULL;
      default: state_nxt = ST_MOVE;
    endcase
  end

  always_comb begin
    move_en = (state_q == ST_MOVE) && step;
    land_en = (state_q == ST_LAND);
  end

  // Divider, drop sampler and datapath; the divider free-runs in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q       <= '0;
      drop_q      <= 1'b0;
      dir_q       <= DIR_RIGHT;
      pos_x_q     <= '0;
      colors_q    <= 32'h0000_0001;
      height_q    <= '0;
      game_over_q <= 1'b0;
    end else begin
      div_q  <= step ? '0 : div_q + DIV_W'(1);
      drop_q <= drop;

      if (move_en) begin
        if (dir_q == DIR_RIGHT) begin
          if (pos_inc < 11'(X_MAX)) begin
            pos_x_q <= pos_inc[9:0];
          end else begin
            pos_x_q <= 10'(X_MAX);
            dir_q   <= DIR_LEFT;
          end
        end else begin
          if (pos_x_q > 10'(STEP)) begin
            pos_x_q <= pos_x_q - 10'(STEP);
          end else begin
            pos_x_q <= '0;
            dir_q   <= DIR_RIGHT;
          end
        end
      end

      if (land_en) begin
        colors_q[{height_inc, 1'b0} +: 2] <= map_color(lfsr_state[1:0]);
        height_q    <= height_inc;
        game_over_q <= land_full;
      end
    end
  end

  assign pos_x     = pos_x_q;
  assign colors    = colors_q;
  assign height    = height_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed self-checking bench for stack_ctrl with a 4-cycle step tick.
module tb_stack_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        drop;
  logic [9:0]  pos_x;
  logic [31:0] colors;
  logic [3:0]  height;
  logic        game_over;

  int n_cmp = 0;
  int n_bad = 0;

  stack_ctrl #(
    .TICK_DIV  (4),
    .STEP      (4),
    .X_MAX     (490),
    .LFSR_SEED (8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .drop      (drop),
    .pos_x     (pos_x),
    .colors    (colors),
    .height    (height),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    drop = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // One-cycle drop pulse, then idle long enough for the landing to complete.
  task automatic do_drop();
    drop = 1'b1;
    @(negedge clk);
    drop = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int          cyc;
    int          last;
    int          steps;
    logic [9:0]  prev;
    logic [9:0]  exp_pos;
    logic        going_right;
    logic [1:0]  slot1;
    logic [9:0]  frz_pos;
    logic [31:0] frz_col;

    // Reset values
    do_reset();
    chk("rst_pos_x", 32'(pos_x), 32'd0);
    chk("rst_colors", colors, 32'h1);
    chk("rst_height", 32'(height), 32'd0);
    chk("rst_game_over", 32'(game_over), 32'd0);

    // Full sweep right to the edge, back to 0, and one step right again
    rst = 1'b0;
    prev = '0; exp_pos = '0; going_right = 1'b1;
    cyc = 0; last = 0; steps = 0;
    while (steps < 247 && cyc < 1200) begin
      @(negedge clk);
      cyc++;
      if (pos_x != prev) begin
        if (going_right) begin
          if (exp_pos == 10'd488) begin
            exp_pos = 10'd490;
            going_right = 1'b0;
          end else begin
            exp_pos = exp_pos + 10'd4;
          end
        end else begin
          if (exp_pos == 10'd2) begin
            exp_pos = 10'd0;
            going_right = 1'b1;
          end else begin
            exp_pos = exp_pos - 10'd4;
          end
        end
        chk("sweep_pos", 32'(pos_x), 32'(exp_pos));
        chk("sweep_period", 32'(cyc - last), 32'd4);
        last = cyc;
        prev = pos_x;
        steps++;
      end
    end
    chk("sweep_steps", 32'(steps), 32'd247);
    chk("sweep_end_pos", 32'(pos_x), 32'd4);

    // Drop edge coincident with the step from 100, then hold drop high
    do_reset();
    rst = 1'b0;
    cyc = 0;
    while (pos_x != 10'd100 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_100_cycle", 32'(cyc), 32'd100);
    repeat (3) @(negedge clk);
    drop = 1'b1;
    @(negedge clk);
    chk("coinc_pos_x", 32'(pos_x), 32'd104);
    chk("coinc_height_n1", 32'(height), 32'd0);
    @(negedge clk);
    chk("coinc_height_n2", 32'(height), 32'd1);
    chk("slot1_nonzero", 32'(colors[3:2] != 2'b00), 32'd1);
    chk("slot0_green", 32'(colors[1:0]), 32'd1);
    slot1 = colors[3:2];
    repeat (100) @(negedge clk);
    chk("hold_height", 32'(height), 32'd1);
    chk("hold_slot1", 32'(colors[3:2]), 32'(slot1));
    chk("hold_upper_empty", colors[31:4], 32'd0);
    drop = 1'b0;
    @(negedge clk);

    // Fill the stack to 15 layers
    for (int k = 2; k <= 15; k++) begin
      drop = 1'b1;
      @(negedge clk);
      drop = 1'b0;
      @(negedge clk);
      chk("fill_height", 32'(height), 32'(k));
      chk("fill_game_over", 32'(game_over), 32'(k == 15));
      repeat (2) @(negedge clk);
    end
    for (int i = 0; i < 16; i++) begin
      chk("full_slot_nonzero", 32'(colors[2*i +: 2] != 2'b00), 32'd1);
    end
    chk("full_slot0", 32'(colors[1:0]), 32'd1);

    // Frozen in FULL: further drops and steps change nothing
    frz_pos = pos_x;
    frz_col = colors;
    for (int i = 0; i < 10; i++) begin
      drop = 1'b1;
      repeat (2) @(negedge clk);
      drop = 1'b0;
      repeat (2) @(negedge clk);
    end
    chk("frozen_pos_x", 32'(pos_x), 32'(frz_pos));
    chk("frozen_colors", colors, frz_col);
    chk("frozen_height", 32'(height), 32'd15);
    chk("frozen_game_over", 32'(game_over), 32'd1);

    // Reset during the LAND cycle of the third drop
    do_reset();
    rst = 1'b0;
    do_drop();
    do_drop();
    chk("pre_land_height", 32'(height), 32'd2);
    drop = 1'b1;
    @(negedge clk);
    rst  = 1'b1;
    drop = 1'b0;
    @(negedge clk);
    chk("landrst_height", 32'(height), 32'd0);
    chk("landrst_colors", colors, 32'h1);
    chk("landrst_pos_x", 32'(pos_x), 32'd0);
    chk("landrst_game_over", 32'(game_over), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    drop = 1'b1;
    @(negedge clk);
    drop = 1'b0;
    @(negedge clk);
    chk("landrst_move_drop", 32'(height), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
